// File: rtl/iic_txn_sequencer.sv
// Register-level I2C transaction sequencer: turns one register write/read request into the
// byte engine's START/WRITE/READ/STOP command stream, polling busy and checking ACKs.
//
// state  | meaning
// BOOT   | post-reset lead-in, no bus activity
// CFG    | single write of SCL_PERIOD to engine register 1
// IDLE   | ready for a request
// ISSUE  | one command write to engine register 0
// SETTLE | SETTLE_CYC quiet cycles while the engine picks up the command
// POLL   | one status read of engine register 0
// CHK    | evaluate status: busy / NACK / read byte
// ABORT  | switch the command stream to a lone STOP
// FIN    | one-cycle done pulse
module iic_txn_sequencer #(
  parameter logic [7:0] SCL_PERIOD = 8'hFF,
  parameter int         SETTLE_CYC = 3,   // must be >= 1
  parameter int         TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        rnw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic        err,
  output logic        err_to,
  output logic [7:0]  rdata,
  output logic [3:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata
);

  typedef enum logic [3:0] {
    S_BOOT, S_CFG, S_IDLE, S_ISSUE, S_SETTLE, S_POLL, S_CHK, S_ABORT, S_FIN
  } state_t;

  localparam logic [15:0] POLL_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t      state, state_nxt;
  logic [2:0]  step;
  logic        abort_q;
  logic [15:0] poll_cnt;
  logic [7:0]  settle_cnt;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [9:0]  cmd;
  logic        last_step;
  logic        wr_step;
  logic        rd_step;
  logic        busy;
  logic        nack;
  logic        poll_hit;
  logic        unused_ok;

  assign busy      = m_readdata[8];
  assign nack      = m_readdata[10];
  assign unused_ok = ^{m_readdata[31:11], m_readdata[9]};

  // Command word for the current step; an aborted transaction only ever sends STOP.
  always_comb begin
    cmd = 10'h200;
    if (!abort_q) begin
      case (step)
        3'd0:    cmd = 10'h100;
        3'd1:    cmd = {2'b00, dev_q, 1'b0};
        3'd2:    cmd = {2'b00, reg_q};
        3'd3:    cmd = rnw_q ? 10'h100 : {2'b00, wdata_q};
        3'd4:    cmd = rnw_q ? {2'b00, dev_q, 1'b1} : 10'h200;
        3'd5:    cmd = 10'h301;
        default: cmd = 10'h200;
      endcase
    end
  end

  assign last_step = rnw_q ? (step == 3'd6) : (step == 3'd4);
  assign wr_step   = (cmd[9:8] == 2'b00);
  assign rd_step   = (cmd[9:8] == 2'b11);
  assign poll_hit  = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:   state_nxt = S_CFG;
      S_CFG:    state_nxt = S_IDLE;
      S_IDLE:   if (req) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 8'd0) state_nxt = S_POLL;
      S_POLL:   state_nxt = S_CHK;
      S_CHK: begin
        if (busy) begin
          if (poll_hit) state_nxt = abort_q ? S_FIN : S_ABORT;
          else          state_nxt = S_POLL;
        end else if (abort_q) begin
          state_nxt = S_FIN;
        end else if (wr_step && nack) begin
          state_nxt = S_ABORT;
        end else begin
          state_nxt = last_step ? S_FIN : S_ISSUE;
        end
      end
      S_ABORT:  state_nxt = S_ISSUE;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    done         = 1'b0;
    m_address    = 4'd0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    m_writedata  = 32'd0;
    case (state)
      S_CFG: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = 4'd1;
        m_writedata  = {24'd0, SCL_PERIOD};
      end
      S_IDLE:  ready = 1'b1;
      S_ISSUE: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_writedata  = {22'd0, cmd};
      end
      S_POLL: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step       <= 3'd0;
      abort_q    <= 1'b0;
      poll_cnt   <= 16'd0;
      settle_cnt <= 8'd0;
      rnw_q      <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      wdata_q    <= 8'd0;
      err        <= 1'b0;
      err_to     <= 1'b0;
      rdata      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          rnw_q   <= rnw;
          dev_q   <= dev_addr;
          reg_q   <= reg_addr;
          wdata_q <= wdata;
          err     <= 1'b0;
          err_to  <= 1'b0;
          step    <= 3'd0;
          abort_q <= 1'b0;
        end
        S_ISSUE: begin
          poll_cnt   <= 16'd0;
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        S_CHK: begin
          if (busy) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_hit) begin
              err    <= 1'b1;
              err_to <= 1'b1;
            end
          end else if (!abort_q) begin
            if (wr_step && nack) begin
              err <= 1'b1;
            end else begin
              if (rd_step) rdata <= m_readdata[7:0];
              step <= step + 3'd1;
            end
          end
        end
        S_ABORT: abort_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_txn_sequencer.sv
// Bench for iic_txn_sequencer: reactive byte-engine model plus a command-list reference
// built directly from the transaction rules.
module tb_iic_txn_sequencer;
  localparam int SETTLE = 3;
  localparam int TOUT   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ready;
  logic        rnw;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic [7:0]  wdata;
  logic        done;
  logic        err;
  logic        err_to;
  logic [7:0]  rdata;
  logic [3:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_read;
  logic [31:0] m_readdata;

  always #5 clk = ~clk;

  iic_txn_sequencer #(.SCL_PERIOD(8'hFF), .SETTLE_CYC(SETTLE), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .rnw(rnw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .done(done), .err(err), .err_to(err_to),
    .rdata(rdata), .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_read(m_read), .m_readdata(m_readdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // engine model state
  logic [9:0]  cmd_q[$];
  int          cyc_q[$];
  int          polls_q[$];
  int          cfg_cnt = 0;
  logic [31:0] cfg_data = 32'd0;
  int          busy_polls = 0;
  logic [9:0]  nack_cmd = 10'h3FF;
  logic [9:0]  stuck_cmd = 10'h3FE;
  logic [7:0]  rd_byte = 8'h00;
  int          busy_left = 0;
  logic        stuck_active = 1'b0;
  logic [9:0]  last_cmd = 10'h000;
  int          viol = 0;
  int          done_cnt = 0;
  int          cyc = 0;

  // reference results
  logic [9:0]  exp_q[$];
  logic        exp_err, exp_to;
  logic [7:0]  exp_rdata = 8'h00;

  initial begin
    m_readdata = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy_left = 0;
        stuck_active = 1'b0;
        m_readdata = 32'd0;
      end else begin
        if (m_write && m_read) viol++;
        if ((m_write || m_read) && !m_chipselect) viol++;
        if (done) done_cnt++;
        if (m_chipselect && m_write) begin
          if (m_address == 4'd1) begin
            cfg_cnt++;
            cfg_data = m_writedata;
          end else begin
            if (busy_left > 0 && !stuck_active) viol++;
            last_cmd = m_writedata[9:0];
            cmd_q.push_back(last_cmd);
            cyc_q.push_back(cyc);
            polls_q.push_back(0);
            stuck_active = 1'b0;
            if (last_cmd == stuck_cmd) begin
              busy_left = 100000;
              stuck_active = 1'b1;
            end else begin
              busy_left = busy_polls;
            end
          end
        end
        if (m_chipselect && m_read && m_address == 4'd0) begin
          if (busy_left > 0) begin
            busy_left--;
            if (polls_q.size() > 0) polls_q[polls_q.size()-1] = polls_q[polls_q.size()-1] + 1;
            m_readdata = {21'd0, 1'b0, 1'b1, 1'b1, 8'h00};
          end else begin
            m_readdata = {21'd0, (last_cmd[9:8] == 2'b00 && last_cmd == nack_cmd), 1'b1, 1'b0,
                          (last_cmd[9:8] == 2'b11) ? rd_byte : 8'h00};
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic build_ref(input logic r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [7:0] wd);
    logic [9:0] full[$];
    logic [9:0] c;
    full.delete();
    full.push_back(10'h100);
    full.push_back({2'b00, d, 1'b0});
    full.push_back({2'b00, ra});
    if (r) begin
      full.push_back(10'h100);
      full.push_back({2'b00, d, 1'b1});
      full.push_back(10'h301);
    end else begin
      full.push_back({2'b00, wd});
    end
    full.push_back(10'h200);
    exp_q.delete();
    exp_err = 1'b0;
    exp_to  = 1'b0;
    for (int i = 0; i < full.size(); i++) begin
      c = full[i];
      exp_q.push_back(c);
      if (c == stuck_cmd) begin
        exp_err = 1'b1;
        exp_to  = 1'b1;
        break;
      end
      if (c[9:8] == 2'b00 && c == nack_cmd) begin
        exp_err = 1'b1;
        break;
      end
      if (c == 10'h301) exp_rdata = rd_byte;
    end
    if (exp_err) exp_q.push_back(10'h200);
  endtask

  task automatic run_txn(input string name, input logic r, input logic [6:0] d,
                         input logic [7:0] ra, input logic [7:0] wd);
    int n;
    int d0;
    int bad_idx;
    int min_gap;
    int bad_poll;
    int want_polls;
    build_ref(r, d, ra, wd);
    cmd_q.delete();
    cyc_q.delete();
    polls_q.delete();
    viol = 0;
    d0 = done_cnt;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
    end
    rnw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
    tick;
    req = 1'b0;
    rnw = 1'($urandom); dev_addr = 7'($urandom); reg_addr = 8'($urandom); wdata = 8'($urandom);
    tick;
    tick;
    req = 1'b1;   // must be ignored while busy
    tick;
    req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick;
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_wait: done=%b required 1 within 3000 cycles", name, done);
    end
    vectors++;
    if (err !== exp_err || err_to !== exp_to) begin
      miscompares++;
      $display("FAIL %s err: err=%b err_to=%b required %b %b", name, err, err_to, exp_err, exp_to);
    end
    vectors++;
    if (rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL %s rdata: got %h required %h", name, rdata, exp_rdata);
    end
    tick;
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b ready=%b required 0 1", name, done, ready);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - d0);
    end
    bad_idx = -1;
    for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++)
      if (bad_idx < 0 && cmd_q[i] !== exp_q[i]) bad_idx = i;
    vectors++;
    if (cmd_q.size() != exp_q.size() || bad_idx >= 0) begin
      miscompares++;
      $display("FAIL %s cmd_seq: got %0d cmds required %0d, first diff idx %0d", name,
               cmd_q.size(), exp_q.size(), bad_idx);
      if (bad_idx >= 0)
        $display("FAIL %s cmd_word: got %h required %h", name, cmd_q[bad_idx], exp_q[bad_idx]);
    end
    min_gap = 1000;
    for (int i = 1; i < cyc_q.size(); i++)
      if (cyc_q[i] - cyc_q[i-1] < min_gap) min_gap = cyc_q[i] - cyc_q[i-1];
    vectors++;
    if (min_gap < SETTLE + 1) begin
      miscompares++;
      $display("FAIL %s cmd_gap: min %0d cycles required >= %0d", name, min_gap, SETTLE + 1);
    end
    bad_poll = -1;
    for (int i = 0; i < polls_q.size(); i++) begin
      want_polls = (cmd_q[i] == stuck_cmd) ? TOUT : busy_polls;
      if (bad_poll < 0 && polls_q[i] != want_polls) bad_poll = i;
    end
    vectors++;
    if (bad_poll >= 0) begin
      miscompares++;
      $display("FAIL %s busy_polls: cmd %0d saw %0d busy polls required %0d", name, bad_poll,
               polls_q[bad_poll], (cmd_q[bad_poll] == stuck_cmd) ? TOUT : busy_polls);
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL %s protocol: %0d violations required 0", name, viol);
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; req = 1'b0; rnw = 1'b0; dev_addr = 7'd0; reg_addr = 8'd0; wdata = 8'd0;
    tick;
    tick;
    vectors++;
    if ({m_chipselect, m_write, m_read, ready, done} !== 5'b0 || m_address !== 4'd0 ||
        m_writedata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bus: cs=%b wr=%b rd=%b ready=%b done=%b addr=%h data=%h required 0",
               m_chipselect, m_write, m_read, ready, done, m_address, m_writedata);
    end
    vectors++;
    if ({err, err_to} !== 2'b00 || rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_status: err=%b err_to=%b rdata=%h required 0", err, err_to, rdata);
    end
    exp_rdata = 8'h00;
    cfg_cnt = 0;
    cfg_data = 32'd0;
    cmd_q.delete();
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ready=%b required 1", ready);
    end
    vectors++;
    if (cfg_cnt != 1 || cfg_data !== 32'h0000_00FF) begin
      miscompares++;
      $display("FAIL cfg_write: count %0d data %h required 1 000000ff", cfg_cnt, cfg_data);
    end
    vectors++;
    if (cmd_q.size() != 0) begin
      miscompares++;
      $display("FAIL cfg_only: %0d engine commands before ready, required 0", cmd_q.size());
    end
  endtask

  task automatic test_write;
    busy_polls = 4; nack_cmd = 10'h3FF; stuck_cmd = 10'h3FE;
    run_txn("write", 1'b0, 7'h50, 8'h10, 8'hA5);
  endtask

  task automatic test_read;
    busy_polls = 4; nack_cmd = 10'h3FF; stuck_cmd = 10'h3FE; rd_byte = 8'h3C;
    run_txn("read", 1'b1, 7'h50, 8'h10, 8'h00);
  endtask

  task automatic test_nack;
    busy_polls = 1; nack_cmd = 10'h0A0; stuck_cmd = 10'h3FE;
    run_txn("nack_addr", 1'b0, 7'h50, 8'h10, 8'hA5);
    nack_cmd = 10'h0A1; rd_byte = 8'h77;
    run_txn("nack_rdaddr", 1'b1, 7'h50, 8'h22, 8'h00);
    nack_cmd = 10'h3FF;
  endtask

  task automatic test_timeout;
    busy_polls = TOUT - 1; nack_cmd = 10'h3FF; stuck_cmd = 10'h3FE;
    run_txn("busy_edge", 1'b0, 7'h21, 8'h05, 8'h5A);
    busy_polls = 2; stuck_cmd = 10'h100;
    run_txn("timeout", 1'b0, 7'h21, 8'h06, 8'h5B);
    stuck_cmd = 10'h3FE;
  endtask

  task automatic test_rst_mid;
    int n;
    int c0;
    int d0;
    busy_polls = 2; nack_cmd = 10'h3FF; stuck_cmd = 10'h3FE;
    cmd_q.delete();
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    rnw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h10; wdata = 8'hA5; req = 1'b1;
    tick;
    req = 1'b0;
    n = 0;
    while (cmd_q.size() < 3 && n < 500) begin
      tick;
      n++;
    end
    vectors++;
    if (cmd_q.size() < 3) begin
      miscompares++;
      $display("FAIL rst_mid_reach: %0d commands seen, required 3", cmd_q.size());
    end
    c0 = cfg_cnt;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    vectors++;
    if ({m_chipselect, m_write, m_read, done, ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_mid_bus: cs=%b wr=%b rd=%b done=%b ready=%b required 0",
               m_chipselect, m_write, m_read, done, ready);
    end
    tick;
    tick;
    rst = 1'b0;
    exp_rdata = 8'h00;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (cfg_cnt - c0 != 1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_cfg: cfg writes %0d ready=%b required 1 1", cfg_cnt - c0, ready);
    end
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL rst_mid_done: %0d done pulses required 0", done_cnt - d0);
    end
    run_txn("after_rst", 1'b0, 7'h50, 8'h10, 8'hA5);
  endtask

  task automatic test_random;
    logic       r;
    logic [6:0] d;
    logic [7:0] ra, wd;
    int         sel;
    for (int k = 0; k < 12; k++) begin
      r  = 1'($urandom);
      d  = 7'($urandom);
      ra = 8'($urandom);
      wd = 8'($urandom);
      rd_byte = 8'($urandom);
      busy_polls = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       nack_cmd = 10'h3FF;
        1:       nack_cmd = {2'b00, d, 1'b0};
        2:       nack_cmd = {2'b00, ra};
        default: nack_cmd = r ? {2'b00, d, 1'b1} : {2'b00, wd};
      endcase
      stuck_cmd = ($urandom_range(0, 7) == 0) ? 10'h100 : 10'h3FE;
      run_txn("random", r, d, ra, wd);
    end
    nack_cmd = 10'h3FF;
    stuck_cmd = 10'h3FE;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nack;
    test_timeout;
    test_rst_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
